// File: rtl/router_register_p.sv
// Parametrised packet data register between the router FSM and the output FIFOs.
// Optional statistics counters are enabled by defining ROUTER_REG_STATS_EN.
module router_register_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int LEN_W  = DATA_W - ADDR_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              rst_int_reg,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err,
    output logic [DATA_W-1:0] dout
`ifdef ROUTER_REG_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       err_cnt,
    output logic [15:0]       len_err_cnt
`endif
);

    localparam int                CNT_W    = LEN_W + 1;
    localparam logic [ADDR_W-1:0] BAD_ADDR = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] full_byte_q, full_byte_d;
    logic [DATA_W-1:0] int_par_q, int_par_d;
    logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CNT_W-1:0]  pay_cnt_q, pay_cnt_d;
    logic              low_q, low_d;
    logic              pd_q, pd_d;
    logic              pd_prev_q, pd_prev_d;
    logic              err_q, err_d;
    logic              len_err_q, len_err_d;

    // State inputs are nominally one-hot; resolve overlaps by fixed priority.
    logic da, lfd, ld, laf;
    assign da  = detect_add;
    assign lfd = lfd_state & ~detect_add;
    assign ld  = ld_state & ~detect_add & ~lfd_state;
    assign laf = laf_state & ~detect_add & ~lfd_state & ~ld_state;

    // Error flags are evaluated once, the cycle after parity_done rises.
    logic pd_rise, par_mismatch, len_mismatch;
    assign pd_rise      = pd_q & ~pd_prev_q;
    assign par_mismatch = (int_par_q != pkt_par_q);
    assign len_mismatch = (pay_cnt_q != {1'b0, hdr_q[DATA_W-1:ADDR_W]});

    always_comb begin
        hdr_d       = hdr_q;
        full_byte_d = full_byte_q;
        int_par_d   = int_par_q;
        pkt_par_d   = pkt_par_q;
        dout_d      = dout_q;
        pay_cnt_d   = pay_cnt_q;
        pd_d        = pd_q;
        pd_prev_d   = pd_q;
        err_d       = err_q;
        len_err_d   = len_err_q;

        low_d = low_q;
        if (rst_int_reg)
            low_d = 1'b0;
        if (ld && !pkt_valid)
            low_d = 1'b1;

        if (da) begin
            if (pkt_valid && (data_in[ADDR_W-1:0] != BAD_ADDR))
                hdr_d = data_in;
            int_par_d = '0;
            pay_cnt_d = '0;
            pd_d      = 1'b0;
            err_d     = 1'b0;
            len_err_d = 1'b0;
        end else begin
            if (lfd) begin
                dout_d    = hdr_q;
                int_par_d = int_par_q ^ hdr_q;
            end
            if (ld) begin
                if (pkt_valid) begin
                    if (fifo_full)
                        full_byte_d = data_in;
                    else
                        dout_d = data_in;
                    // A byte parked in full_byte is counted here, never on replay.
                    if (!full_state) begin
                        int_par_d = int_par_q ^ data_in;
                        if (pay_cnt_q != CNT_MAX)
                            pay_cnt_d = pay_cnt_q + CNT_ONE;
                    end
                end else if (fifo_full) begin
                    full_byte_d = data_in;
                end else begin
                    dout_d    = data_in;
                    pkt_par_d = data_in;
                    pd_d      = 1'b1;
                end
            end
            if (laf) begin
                dout_d = full_byte_q;
                if (low_q && !pd_q) begin
                    pkt_par_d = full_byte_q;
                    pd_d      = 1'b1;
                end
            end
            if (pd_rise) begin
                err_d     = par_mismatch;
                len_err_d = len_mismatch;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            hdr_q       <= '0;
            full_byte_q <= '0;
            int_par_q   <= '0;
            pkt_par_q   <= '0;
            dout_q      <= '0;
            pay_cnt_q   <= '0;
            low_q       <= 1'b0;
            pd_q        <= 1'b0;
            pd_prev_q   <= 1'b0;
            err_q       <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            hdr_q       <= hdr_d;
            full_byte_q <= full_byte_d;
            int_par_q   <= int_par_d;
            pkt_par_q   <= pkt_par_d;
            dout_q      <= dout_d;
            pay_cnt_q   <= pay_cnt_d;
            low_q       <= low_d;
            pd_q        <= pd_d;
            pd_prev_q   <= pd_prev_d;
            err_q       <= err_d;
            len_err_q   <= len_err_d;
        end
    end

    assign parity_done   = pd_q;
    assign low_pkt_valid = low_q;
    assign err           = err_q;
    assign len_err       = len_err_q;
    assign dout          = dout_q;

`ifdef ROUTER_REG_STATS_EN
    logic [15:0] pkt_cnt_q, err_cnt_q, len_err_cnt_q;

    always_ff @(posedge clock) begin
        if (resetn) begin
            pkt_cnt_q     <= '0;
            err_cnt_q     <= '0;
            len_err_cnt_q <= '0;
        end else begin
            if (pd_rise)
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (pd_rise && !da && par_mismatch)
                err_cnt_q <= err_cnt_q + 16'd1;
            if (pd_rise && !da && len_mismatch)
                len_err_cnt_q <= len_err_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt     = pkt_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign len_err_cnt = len_err_cnt_q;
`endif

endmodule

// File: tb/tb_router_register_p.sv
// Directed bench for router_register_p: a vector table plus multi-cycle packet sequences.
module tb_router_register_p;

    logic       clock = 1'b0;
    logic       resetn, pkt_valid, fifo_full, rst_int_reg;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic [7:0] data_in;
    logic       parity_done, low_pkt_valid, err, len_err;
    logic [7:0] dout;
`ifdef ROUTER_REG_STATS_EN
    logic [15:0] pkt_cnt, err_cnt, len_err_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    router_register_p dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .rst_int_reg  (rst_int_reg),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err),
        .len_err      (len_err),
        .dout         (dout)
`ifdef ROUTER_REG_STATS_EN
        ,
        .pkt_cnt      (pkt_cnt),
        .err_cnt      (err_cnt),
        .len_err_cnt  (len_err_cnt)
`endif
    );

    always #5 clock = ~clock;

    // ctl = {resetn,pkt_valid,fifo_full,rst_int_reg,detect_add,lfd,ld,laf,full}
    // flg = {parity_done,low_pkt_valid,err,len_err}
    typedef struct packed {
        logic [8:0] ctl;
        logic [7:0] din;
        logic [3:0] flg;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl [18];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        resetn = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0; rst_int_reg = 1'b0;
        detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0;
        full_state = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One packet; parity byte is built from the header and the bytes actually sent.
    task automatic send_pkt(input logic [7:0] h, input int n, input logic [7:0] flip,
                            input int full_at, input bit par_full,
                            input logic exp_err, input logic exp_len);
        logic [7:0] par, b, pb, prev;
        idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = h; step();
        idle(); lfd_state = 1'b1; pkt_valid = 1'b1; step();
        chk("hdr_on_dout", 16'(dout), 16'(h));
        par  = h;
        prev = h;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            par = par ^ b;
            idle(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = b; fifo_full = (i == full_at);
            step();
            if (i == full_at) begin
                chk("dout_hold_on_full", 16'(dout), 16'(prev));
                idle(); full_state = 1'b1; fifo_full = 1'b1; pkt_valid = 1'b1; step(); step();
                idle(); laf_state = 1'b1; pkt_valid = 1'b1; step();
                chk("laf_replay", 16'(dout), 16'(b));
            end else begin
                chk("payload", 16'(dout), 16'(b));
            end
            prev = b;
        end
        pb = par ^ flip;
        idle(); ld_state = 1'b1; pkt_valid = 1'b0; data_in = pb; fifo_full = par_full; step();
        if (!par_full) begin
            chk("parity_on_dout", 16'(dout), 16'(pb));
            chk("pd_set", 16'(parity_done), 16'(1'b1));
        end else begin
            chk("pd_wait_full", 16'(parity_done), 16'(1'b0));
            chk("lpv_set", 16'(low_pkt_valid), 16'(1'b1));
            idle(); full_state = 1'b1; fifo_full = 1'b1; step();
            idle(); laf_state = 1'b1; step();
            chk("laf_parity_dout", 16'(dout), 16'(pb));
            chk("pd_set_in_laf", 16'(parity_done), 16'(1'b1));
        end
        idle(); rst_int_reg = 1'b1; step();
        chk("pd_hold", 16'(parity_done), 16'(1'b1));
        chk("err", 16'(err), 16'(exp_err));
        chk("len_err", 16'(len_err), 16'(exp_len));
        chk("lpv_clear", 16'(low_pkt_valid), 16'(1'b0));
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        data_in = 8'h00;

        tbl[0]  = '{9'b1_0000_0000, 8'h00, 4'b0000, 8'h00};
        tbl[1]  = '{9'b0_1001_0000, 8'h08, 4'b0000, 8'h00};
        tbl[2]  = '{9'b0_1000_1000, 8'h11, 4'b0000, 8'h08};
        tbl[3]  = '{9'b0_1000_0100, 8'h11, 4'b0000, 8'h11};
        tbl[4]  = '{9'b0_1000_0100, 8'h22, 4'b0000, 8'h22};
        tbl[5]  = '{9'b0_0000_0100, 8'h3B, 4'b1100, 8'h3B};
        tbl[6]  = '{9'b0_0010_0000, 8'h3B, 4'b1000, 8'h3B};
        tbl[7]  = '{9'b0_1001_0000, 8'h01, 4'b0000, 8'h3B};
        tbl[8]  = '{9'b0_1000_1000, 8'h01, 4'b0000, 8'h01};
        tbl[9]  = '{9'b0_0000_0100, 8'hFF, 4'b1100, 8'hFF};
        tbl[10] = '{9'b0_0010_0000, 8'hFF, 4'b1010, 8'hFF};
        tbl[11] = '{9'b0_0110_0100, 8'h5A, 4'b1110, 8'hFF};
        tbl[12] = '{9'b0_1011_0000, 8'h4B, 4'b0000, 8'hFF};
        tbl[13] = '{9'b0_1000_1000, 8'h00, 4'b0000, 8'h01};
        tbl[14] = '{9'b0_1001_0100, 8'h24, 4'b0000, 8'h01};
        tbl[15] = '{9'b0_1000_1000, 8'h00, 4'b0000, 8'h24};
        tbl[16] = '{9'b1_1000_0100, 8'h55, 4'b0000, 8'h00};
        tbl[17] = '{9'b0_0000_1000, 8'h00, 4'b0000, 8'h00};

        for (int i = 0; i < 18; i++) begin
            {resetn, pkt_valid, fifo_full, rst_int_reg, detect_add,
             lfd_state, ld_state, laf_state, full_state} = tbl[i].ctl;
            data_in = tbl[i].din;
            step();
            chk($sformatf("vec%0d.dout", i), 16'(dout), 16'(tbl[i].dout));
            chk($sformatf("vec%0d.parity_done", i), 16'(parity_done), 16'(tbl[i].flg[3]));
            chk($sformatf("vec%0d.low_pkt_valid", i), 16'(low_pkt_valid), 16'(tbl[i].flg[2]));
            chk($sformatf("vec%0d.err", i), 16'(err), 16'(tbl[i].flg[1]));
            chk($sformatf("vec%0d.len_err", i), 16'(len_err), 16'(tbl[i].flg[0]));
        end
        idle();

        send_pkt(8'h4A, 18, 8'h00, -1, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h4A, 18, 8'h01, -1, 1'b0, 1'b1, 1'b0);
        idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h04; step();
        chk("err_clr_on_da", 16'(err), 16'(1'b0));
        chk("pd_clr_on_da", 16'(parity_done), 16'(1'b0));
        send_pkt(8'h4A, 17, 8'h00, -1, 1'b0, 1'b0, 1'b1);
        send_pkt(8'h4A, 18, 8'h00, 4, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h4A, 18, 8'h00, -1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a payload discards everything.
        idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h4A; step();
        idle(); lfd_state = 1'b1; pkt_valid = 1'b1; step();
        idle(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h33; step();
        chk("pre_rst_dout", 16'(dout), 16'h0033);
        idle(); resetn = 1'b1; ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h44; step();
        chk("rst_dout", 16'(dout), 16'h0000);
        chk("rst_flags", 16'({parity_done, low_pkt_valid, err, len_err}), 16'h0000);
        idle(); lfd_state = 1'b1; step();
        chk("rst_hdr", 16'(dout), 16'h0000);

`ifdef ROUTER_REG_STATS_EN
        idle(); resetn = 1'b1; step();
        chk("stats_rst", 16'(pkt_cnt | err_cnt | len_err_cnt), 16'h0000);
        send_pkt(8'h4A, 18, 8'h00, -1, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h4A, 18, 8'h80, -1, 1'b0, 1'b1, 1'b0);
        send_pkt(8'h0C, 3, 8'h00, -1, 1'b0, 1'b0, 1'b0);
        chk("pkt_cnt", pkt_cnt, 16'd3);
        chk("err_cnt", err_cnt, 16'd1);
        chk("len_err_cnt", len_err_cnt, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/router_register_p.md
Name: router_register_p

Overview:
- Parametrised packet data register for the 1xN router datapath, the successor to the fixed 8-bit router register.
- Sits between the router FSM and the output FIFOs.
- Latches the header and holds the byte arriving while the FIFO is full, so that byte is replayed later.
- Accumulates running XOR parity, captures the packet parity byte, and flags parity errors.
- New over the previous generation: configurable data and address widths, a payload-length checker, and explicit error clearing per packet.

Parameters:
- DATA_W, 8, width of data bytes on data_in/dout.
- ADDR_W, 2, width of the destination address field in header bits [ADDR_W-1:0]; the all-ones address is invalid.
- LEN_W, DATA_W-ADDR_W, width of the payload-length field in header bits [DATA_W-1:ADDR_W].

Ports:
- clock input 1: system clock; all logic on posedge.
- resetn input 1: synchronous, active-high reset (resetn=1 at posedge resets).
- pkt_valid input 1: source asserts for header+payload, deasserts with the parity byte.
- data_in input DATA_W: packet byte from source.
- fifo_full input 1: selected output FIFO full.
- rst_int_reg input 1: FSM clears low_pkt_valid.
- detect_add input 1: FSM DECODE_ADDRESS state.
- lfd_state input 1: FSM LOAD_FIRST_DATA state.
- ld_state input 1: FSM LOAD_DATA state.
- laf_state input 1: FSM LOAD_AFTER_FULL state.
- full_state input 1: FSM FIFO_FULL_STATE.
- parity_done output 1: packet parity byte has been captured.
- low_pkt_valid output 1: pkt_valid fell during ld_state.
- err output 1: parity mismatch for the current packet.
- len_err output 1: payload byte count differs from the header length field.
- dout output DATA_W: byte to the FIFO write port.

Behaviour:
- Reset: all outputs are 0 and all internal registers are 0 (hdr, full_byte, int_par, pkt_par, pay_cnt).
- Priority: resetn over all else. The FSM state inputs are one-hot. If more than one is asserted, the priority is detect_add > lfd_state > ld_state > laf_state.
- Header capture: when detect_add & pkt_valid & data_in[ADDR_W-1:0] != all-ones, hdr <= data_in. With an invalid address, hdr is unchanged.
- lfd_state: dout <= hdr, one cycle after header capture.
- ld_state & pkt_valid:
  - !fifo_full: dout <= data_in.
  - fifo_full: full_byte <= data_in; dout holds.
- ld_state & !pkt_valid (parity byte):
  - !fifo_full: dout <= data_in and pkt_par <= data_in.
  - fifo_full: full_byte <= data_in.
- laf_state: dout <= full_byte. If low_pkt_valid & !parity_done, also pkt_par <= full_byte.
- Otherwise: dout holds.
- low_pkt_valid: set on ld_state & !pkt_valid; cleared on rst_int_reg; set wins if both occur in the same cycle.
- parity_done:
  - Set on (ld_state & !fifo_full & !pkt_valid), or on (laf_state & low_pkt_valid & !parity_done).
  - Cleared on detect_add.
  - Stays set until cleared.
- int_par:
  - detect_add: cleared to 0.
  - lfd_state: ^= hdr.
  - ld_state & pkt_valid & !full_state: ^= data_in.
  - The byte held during fifo_full is counted exactly once, at arrival.
- pay_cnt (LEN_W+1 bits, saturating at max):
  - detect_add: cleared.
  - ld_state & pkt_valid & !full_state: increments.
- err / len_err:
  - Evaluated in the cycle after parity_done rises.
  - err <= (int_par != pkt_par).
  - len_err <= (pay_cnt != hdr[DATA_W-1:ADDR_W]).
  - Both clear on detect_add; otherwise they hold.
- Latency: the header appears on dout 2 cycles after the detect_add cycle; payload has 1-cycle latency from data_in to dout.
- Zero-length payload (length field 0): the parity byte directly follows the header. parity_done and err behave normally; len_err = 0.
- Reset mid-packet: state is discarded. The next packet requires a fresh detect_add.

Optional Feature:
- Macro: ROUTER_REG_STATS_EN.
- Enabled:
  - Adds outputs pkt_cnt[15:0], err_cnt[15:0], len_err_cnt[15:0].
  - pkt_cnt increments on each parity_done rising edge.
  - err_cnt and len_err_cnt increment when err or len_err is set.
  - All three counters wrap at 16'hFFFF -> 0 and are cleared by resetn.
- Disabled: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Default params, header 8'h4A (len 18, addr 2), 18 random payload bytes, correct parity byte, fifo_full=0 -> dout carries 4A then each payload byte with 1-cycle lag; parity_done=1; err=0; len_err=0.
- Same packet with parity byte XORed by 8'h01 -> err=1 one cycle after parity_done. The next detect_add clears err and parity_done.
- Header 8'h4A, only 17 payload bytes then parity -> len_err=1, err=0 (parity computed over the bytes actually sent).
- fifo_full=1 on payload byte 5, FSM goes full_state then laf_state -> full_byte is replayed on dout in laf; parity is counted once; err=0. Repeat with fifo_full on the parity byte -> parity_done sets in laf via low_pkt_valid.
- Header 8'h4B (addr 3) under detect_add -> hdr unchanged. resetn=1 mid-payload -> all outputs 0 next cycle.
- ROUTER_REG_STATS_EN: 3 packets, one with bad parity -> pkt_cnt=3, err_cnt=1, len_err_cnt=0.
